// File: rtl/ahb_lite_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_interconnect
// Description : Single-master AHB-Lite interconnect. It decodes the upstream
//               address against per-port base/mask windows, broadcasts the
//               request to every downstream port, and muxes the response back
//               from the port that owns the data phase. An internal default
//               slave answers unmapped NONSEQ/SEQ transfers with a two-cycle
//               ERROR response and counts them.
// Ports       : HCLK, HRESETn         - clock, synchronous active-low reset
//               s_H*                  - upstream master request / response
//               m_H*                  - per-port request (out) / response (in)
//               err_count             - saturating count of default-slave errors
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_interconnect #(
    parameter int HDATA_WIDTH = 32,
    parameter int HADDR_WIDTH = 32,
    parameter int HPORT_COUNT = 4,
    parameter logic [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] PORT_BASE = '0,
    parameter logic [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] PORT_MASK = '0
) (
    input  logic                                    HCLK,
    input  logic                                    HRESETn,
    // upstream request
    input  logic [HADDR_WIDTH-1:0]                  s_HADDR,
    input  logic [2:0]                              s_HBURST,
    input  logic                                    s_HMASTLOCK,
    input  logic [3:0]                              s_HPROT,
    input  logic [2:0]                              s_HSIZE,
    input  logic [1:0]                              s_HTRANS,
    input  logic [HDATA_WIDTH-1:0]                  s_HWDATA,
    input  logic                                    s_HWRITE,
    // upstream response
    output logic [HDATA_WIDTH-1:0]                  s_HRDATA,
    output logic                                    s_HREADY,
    output logic                                    s_HRESP,
    // per-port request
    output logic [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] m_HADDR,
    output logic [HPORT_COUNT-1:0][2:0]             m_HBURST,
    output logic [HPORT_COUNT-1:0]                  m_HMASTLOCK,
    output logic [HPORT_COUNT-1:0][3:0]             m_HPROT,
    output logic [HPORT_COUNT-1:0][2:0]             m_HSIZE,
    output logic [HPORT_COUNT-1:0][1:0]             m_HTRANS,
    output logic [HPORT_COUNT-1:0][HDATA_WIDTH-1:0] m_HWDATA,
    output logic [HPORT_COUNT-1:0]                  m_HWRITE,
    output logic [HPORT_COUNT-1:0]                  m_HSEL,
    output logic [HPORT_COUNT-1:0]                  m_HREADY,
    // per-port response
    input  logic [HPORT_COUNT-1:0][HDATA_WIDTH-1:0] m_HRDATA,
    input  logic [HPORT_COUNT-1:0]                  m_HREADYOUT,
    input  logic [HPORT_COUNT-1:0]                  m_HRESP,
    // status
    output logic [15:0]                             err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dflt_state_t;

    localparam logic [15:0] c_err_max = 16'hFFFF;

    logic [HPORT_COUNT-1:0] w_hsel;
    logic                   w_miss;
    logic                   w_active;

    logic [HPORT_COUNT-1:0] w_sel_d;
    logic [HPORT_COUNT-1:0] r_sel_q;
    logic                   w_dflt_d;
    logic                   r_dflt_q;

    dflt_state_t            w_state_d;
    dflt_state_t            r_state_q;
    logic [15:0]            w_err_d;
    logic [15:0]            r_err_q;

    logic                   w_dflt_ready;
    logic                   w_dflt_resp;

    // ------------------------------------------------------------------
    // Address decode: first (lowest-index) enabled window that matches wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_hsel = '0;
        w_miss = 1'b1;
        for (int i = 0; i < HPORT_COUNT; i++) begin
            if (w_miss && (PORT_MASK[i] != '0) &&
                ((s_HADDR & PORT_MASK[i]) == (PORT_BASE[i] & PORT_MASK[i]))) begin
                w_hsel[i] = 1'b1;
                w_miss    = 1'b0;
            end
        end
    end

    assign w_active = s_HTRANS[1];   // NONSEQ or SEQ

    // ------------------------------------------------------------------
    // Request broadcast; every port sees the same address phase.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < HPORT_COUNT; gi++) begin : g_port
            assign m_HADDR[gi]     = s_HADDR;
            assign m_HBURST[gi]    = s_HBURST;
            assign m_HMASTLOCK[gi] = s_HMASTLOCK;
            assign m_HPROT[gi]     = s_HPROT;
            assign m_HSIZE[gi]     = s_HSIZE;
            assign m_HTRANS[gi]    = s_HTRANS;
            assign m_HWDATA[gi]    = s_HWDATA;
            assign m_HWRITE[gi]    = s_HWRITE;
        end
    endgenerate

    assign m_HSEL    = w_hsel;
    assign m_HREADY  = {HPORT_COUNT{s_HREADY}};
    assign err_count = r_err_q;

    // ------------------------------------------------------------------
    // Data-phase owner: captured with every completed address phase.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_d  = r_sel_q;
        w_dflt_d = r_dflt_q;
        if (s_HREADY) begin
            w_sel_d  = w_hsel;
            w_dflt_d = w_miss;
        end
    end

    // ------------------------------------------------------------------
    // Default slave response, a function of its state only. Kept apart
    // from the next-state logic so no loop forms through s_HREADY.
    // ------------------------------------------------------------------
    always_comb begin
        w_dflt_ready = 1'b1;
        w_dflt_resp  = 1'b0;
        unique case (r_state_q)
            ST_ERR1: begin
                w_dflt_ready = 1'b0;
                w_dflt_resp  = 1'b1;
            end
            ST_ERR2: begin
                w_dflt_resp  = 1'b1;
            end
            default: ;
        endcase
    end

    // Default slave next state and error counter.
    always_comb begin
        w_state_d = r_state_q;
        w_err_d   = r_err_q;
        unique case (r_state_q)
            ST_IDLE: begin
                if (s_HREADY && w_miss && w_active) begin
                    w_state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                w_state_d = ST_ERR2;
            end
            ST_ERR2: begin
                if (s_HREADY && w_miss && w_active) begin
                    w_state_d = ST_ERR1;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        // ERR1 is only ever entered from another state, so this counts entries.
        if ((w_state_d == ST_ERR1) && (r_err_q != c_err_max)) begin
            w_err_d = r_err_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Response mux. Ports not owning the data phase are ignored entirely.
    // ------------------------------------------------------------------
    always_comb begin
        s_HRDATA = '0;
        s_HREADY = w_dflt_ready;
        s_HRESP  = w_dflt_resp;
        if (!r_dflt_q) begin
            s_HREADY = 1'b0;
            s_HRESP  = 1'b0;
            for (int i = 0; i < HPORT_COUNT; i++) begin
                if (r_sel_q[i]) begin
                    s_HRDATA = s_HRDATA | m_HRDATA[i];
                    s_HREADY = s_HREADY | m_HREADYOUT[i];
                    s_HRESP  = s_HRESP  | m_HRESP[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_sel_q   <= '0;
            r_dflt_q  <= 1'b1;
            r_state_q <= ST_IDLE;
            r_err_q   <= 16'd0;
        end else begin
            r_sel_q   <= w_sel_d;
            r_dflt_q  <= w_dflt_d;
            r_state_q <= w_state_d;
            r_err_q   <= w_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_interconnect
// Description : Self-checking bench for ahb_lite_interconnect. A randomized
//               master issues pipelined transfers and pushes the expected
//               data-phase response into a scoreboard; a monitor pops and
//               compares whenever the interconnect completes a data phase.
//               Behavioural slaves insert random wait states and drive noise
//               whenever they do not own the data phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_interconnect;

    localparam int NP = 5;

    // port0 0x0xxxxxxx, port1 0x1xxxxxxx, port2 0x10xxxxxx (shadowed by
    // port1), port3 0x2xxxxxxx, port4 disabled (mask 0)
    localparam logic [NP-1:0][31:0] c_base = {32'hF000_0000, 32'h2000_0000,
                                              32'h1000_0000, 32'h1000_0000,
                                              32'h0000_0000};
    localparam logic [NP-1:0][31:0] c_mask = {32'h0000_0000, 32'hF000_0000,
                                              32'hFF00_0000, 32'hF000_0000,
                                              32'hF000_0000};

    localparam int K_IDLE_PORT = 0;
    localparam int K_ACT_PORT  = 1;
    localparam int K_ACT_MISS  = 2;
    localparam int K_IDLE_MISS = 3;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] addr;
    } exp_t;

    logic                  HCLK;
    logic                  HRESETn;
    logic [31:0]           s_HADDR;
    logic [2:0]            s_HBURST;
    logic                  s_HMASTLOCK;
    logic [3:0]            s_HPROT;
    logic [2:0]            s_HSIZE;
    logic [1:0]            s_HTRANS;
    logic [31:0]           s_HWDATA;
    logic                  s_HWRITE;
    logic [31:0]           s_HRDATA;
    logic                  s_HREADY;
    logic                  s_HRESP;
    logic [NP-1:0][31:0]   m_HADDR;
    logic [NP-1:0][2:0]    m_HBURST;
    logic [NP-1:0]         m_HMASTLOCK;
    logic [NP-1:0][3:0]    m_HPROT;
    logic [NP-1:0][2:0]    m_HSIZE;
    logic [NP-1:0][1:0]    m_HTRANS;
    logic [NP-1:0][31:0]   m_HWDATA;
    logic [NP-1:0]         m_HWRITE;
    logic [NP-1:0]         m_HSEL;
    logic [NP-1:0]         m_HREADY;
    logic [NP-1:0][31:0]   m_HRDATA;
    logic [NP-1:0]         m_HREADYOUT;
    logic [NP-1:0]         m_HRESP;
    logic [15:0]           err_count;

    ahb_lite_interconnect #(
        .HDATA_WIDTH (32),
        .HADDR_WIDTH (32),
        .HPORT_COUNT (NP),
        .PORT_BASE   (c_base),
        .PORT_MASK   (c_mask)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .s_HADDR     (s_HADDR),
        .s_HBURST    (s_HBURST),
        .s_HMASTLOCK (s_HMASTLOCK),
        .s_HPROT     (s_HPROT),
        .s_HSIZE     (s_HSIZE),
        .s_HTRANS    (s_HTRANS),
        .s_HWDATA    (s_HWDATA),
        .s_HWRITE    (s_HWRITE),
        .s_HRDATA    (s_HRDATA),
        .s_HREADY    (s_HREADY),
        .s_HRESP     (s_HRESP),
        .m_HADDR     (m_HADDR),
        .m_HBURST    (m_HBURST),
        .m_HMASTLOCK (m_HMASTLOCK),
        .m_HPROT     (m_HPROT),
        .m_HSIZE     (m_HSIZE),
        .m_HTRANS    (m_HTRANS),
        .m_HWDATA    (m_HWDATA),
        .m_HWRITE    (m_HWRITE),
        .m_HSEL      (m_HSEL),
        .m_HREADY    (m_HREADY),
        .m_HRDATA    (m_HRDATA),
        .m_HREADYOUT (m_HREADYOUT),
        .m_HRESP     (m_HRESP),
        .err_count   (err_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [15:0] exp_err = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Address map from the window rules: first enabled window that covers a.
    function automatic int ref_port(input logic [31:0] a);
        for (int p = 0; p < NP; p++) begin
            if (c_mask[p] != 32'h0 && ((a ^ c_base[p]) & c_mask[p]) == 32'h0) return p;
        end
        return -1;
    endfunction

    // Read data a slave returns: its index in the top nibble, address below.
    function automatic logic [31:0] pattern(input int p, input logic [31:0] a);
        logic [3:0] pp;
        pp = p[3:0];
        return {pp, a[27:0]};
    endfunction

    // ---------------------------------------------------------------
    // Behavioural slaves
    // ---------------------------------------------------------------
    logic [NP-1:0] sl_dsel = '0, sl_busy = '0, n_dsel, n_busy;
    int            sl_waits[NP], n_waits[NP];
    logic [31:0]   sl_addr[NP], n_addr[NP], g_data[NP];
    logic [NP-1:0] g_rdy = '0, g_resp = '0;

    initial begin
        for (int i = 0; i < NP; i++) begin
            sl_waits[i] = 0;
            sl_addr[i]  = 32'h0;
            g_data[i]   = 32'h0;
        end
    end

    always @(negedge HCLK) begin
        for (int i = 0; i < NP; i++) begin
            n_dsel[i]  = sl_dsel[i];
            n_busy[i]  = sl_busy[i];
            n_waits[i] = sl_waits[i];
            n_addr[i]  = sl_addr[i];
            if (!HRESETn) begin
                n_dsel[i]  = 1'b0;
                n_busy[i]  = 1'b0;
                n_waits[i] = 0;
            end else if (m_HREADY[i]) begin
                n_dsel[i]  = m_HSEL[i];
                n_busy[i]  = m_HSEL[i] && m_HTRANS[i][1];
                n_waits[i] = $urandom_range(0, 3);
                n_addr[i]  = m_HADDR[i];
            end else if (sl_busy[i] && sl_waits[i] > 0) begin
                n_waits[i] = sl_waits[i] - 1;
            end
        end
    end

    always @(posedge HCLK) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            sl_dsel[i]  = n_dsel[i];
            sl_busy[i]  = n_busy[i];
            sl_waits[i] = n_waits[i];
            sl_addr[i]  = n_addr[i];
            g_data[i]   = $urandom;
            g_rdy[i]    = 1'($urandom_range(0, 1));
            g_resp[i]   = 1'($urandom_range(0, 1));
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            m_HRDATA[i]    = sl_busy[i] ? pattern(i, sl_addr[i]) : g_data[i];
            m_HREADYOUT[i] = sl_dsel[i] ? (sl_busy[i] ? (sl_waits[i] == 0) : 1'b1) : g_rdy[i];
            m_HRESP[i]     = sl_dsel[i] ? 1'b0 : g_resp[i];
        end
    end

    // ---------------------------------------------------------------
    // Monitor: compares every cycle, pops on each completed data phase
    // ---------------------------------------------------------------
    logic saw_rst = 1'b0;
    int   nw = 0;

    always @(negedge HCLK) begin
        exp_t        e;
        logic [NP-1:0] exp_sel;
        logic        bc_ok;
        int          p;
        if (!HRESETn) begin
            sb.delete();
            exp_err = 16'd0;
            saw_rst = 1'b1;
            nw      = 0;
        end else begin
            if (saw_rst) begin
                chk("reset_hready", 32'(s_HREADY), 32'd1);
                chk("reset_hresp", 32'(s_HRESP), 32'd0);
                chk("reset_hrdata", s_HRDATA, 32'd0);
                chk("reset_err_count", 32'(err_count), 32'd0);
                saw_rst = 1'b0;
            end
            p       = ref_port(s_HADDR);
            exp_sel = (p >= 0) ? (NP'(1) << p) : '0;
            chk("hsel", 32'(m_HSEL), 32'(exp_sel));
            chk("hready_bcast", 32'(m_HREADY), 32'({NP{s_HREADY}}));
            bc_ok = 1'b1;
            for (int i = 0; i < NP; i++) begin
                if (m_HADDR[i] !== s_HADDR || m_HBURST[i] !== s_HBURST ||
                    m_HMASTLOCK[i] !== s_HMASTLOCK || m_HPROT[i] !== s_HPROT ||
                    m_HSIZE[i] !== s_HSIZE || m_HTRANS[i] !== s_HTRANS ||
                    m_HWDATA[i] !== s_HWDATA || m_HWRITE[i] !== s_HWRITE) bc_ok = 1'b0;
            end
            chk("req_bcast", 32'(bc_ok), 32'd1);
            chk("err_count", 32'(err_count), 32'(exp_err));

            if (sb.size() == 0) begin
                if (!s_HREADY) chk("unexpected_stall", 32'(s_HREADY), 32'd1);
            end else if (s_HREADY) begin
                e = sb.pop_front();
                case (e.kind)
                    K_ACT_PORT: begin
                        chk("port_rdata", s_HRDATA, pattern(e.port, e.addr));
                        chk("port_resp", 32'(s_HRESP), 32'd0);
                        chk("port_waits_le3", 32'(nw <= 3), 32'd1);
                    end
                    K_ACT_MISS: begin
                        chk("err2_resp", 32'(s_HRESP), 32'd1);
                        chk("err2_rdata", s_HRDATA, 32'd0);
                        chk("err_waits", 32'(nw), 32'd1);
                    end
                    K_IDLE_MISS: begin
                        chk("idle_miss_resp", 32'(s_HRESP), 32'd0);
                        chk("idle_miss_rdata", s_HRDATA, 32'd0);
                        chk("idle_miss_waits", 32'(nw), 32'd0);
                    end
                    default: begin
                        chk("idle_port_resp", 32'(s_HRESP), 32'd0);
                        chk("idle_port_waits", 32'(nw), 32'd0);
                    end
                endcase
                nw = 0;
            end else begin
                nw++;
                e = sb[0];
                chk("wait_resp", 32'(s_HRESP), (e.kind == K_ACT_MISS) ? 32'd1 : 32'd0);
                if (nw > 8) begin
                    chk("stall_timeout", 32'(nw), 32'd8);
                    sb.delete();
                    nw = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Master driver
    // ---------------------------------------------------------------
    task automatic push_cur();
        exp_t e;
        int   p;
        p      = ref_port(s_HADDR);
        e.port = p;
        e.addr = s_HADDR;
        if (p >= 0) e.kind = s_HTRANS[1] ? K_ACT_PORT : K_IDLE_PORT;
        else        e.kind = s_HTRANS[1] ? K_ACT_MISS : K_IDLE_MISS;
        if (p < 0 && s_HTRANS[1] && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        sb.push_back(e);
    endtask

    task automatic set_req(input logic [31:0] a, input logic [1:0] t);
        s_HADDR     = a;
        s_HTRANS    = t;
        s_HWRITE    = 1'($urandom_range(0, 1));
        s_HBURST    = 3'($urandom_range(0, 7));
        s_HMASTLOCK = 1'($urandom_range(0, 1));
        s_HPROT     = 4'($urandom_range(0, 15));
        s_HSIZE     = 3'($urandom_range(0, 2));
        s_HWDATA    = $urandom;
    endtask

    // Waits for the current address phase to be accepted, then presents the next.
    task automatic issue(input logic [31:0] a, input logic [1:0] t);
        logic acc;
        for (int k = 0; k < 20; k++) begin
            @(negedge HCLK);
            acc = s_HREADY && HRESETn;
            @(posedge HCLK);
            if (acc) push_cur();
            #1;
            if (acc) begin
                set_req(a, t);
                return;
            end
        end
        chk("issue_timeout", 32'd0, 32'd1);
        set_req(a, t);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0:       return {4'h0, r[27:0]};
            1:       return {4'h1, r[27:0]};
            2:       return {8'h10, r[23:0]};
            3:       return {4'h2, r[27:0]};
            4:       return {4'hF, r[27:0]};
            5:       return {4'h3, r[27:0]};
            default: return {4'h8, r[27:0]};
        endcase
    endfunction

    function automatic logic [1:0] rand_trans();
        int w;
        w = $urandom_range(0, 99);
        if (w < 40) return 2'b10;
        if (w < 60) return 2'b11;
        if (w < 85) return 2'b00;
        return 2'b01;
    endfunction

    initial begin
        HRESETn = 1'b0;
        set_req(32'h0, 2'b00);
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // directed: hit on port1, overlap window, unmapped idle, two back-to-back errors
        issue(32'h1000_0004, 2'b10);
        issue(32'h1000_0008, 2'b10);
        issue(32'hF000_0000, 2'b00);
        issue(32'hF000_0000, 2'b10);
        issue(32'h3000_0000, 2'b11);
        issue(32'h0000_0040, 2'b10);

        for (int n = 0; n < 2500; n++) issue(rand_addr(), rand_trans());

        // reset while the default slave is in its first error cycle
        issue(32'hF000_0000, 2'b10);
        issue(32'h0000_0000, 2'b00);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1 HRESETn = 1'b1;

        for (int n = 0; n < 300; n++) issue(rand_addr(), rand_trans());
        for (int n = 0; n < 6; n++) issue(32'h0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_lite_interconnect.md
AHB_LITE_INTERCONNECT -- requirements
Module: ahb_lite_interconnect

Interface
REQ-001 The block SHALL have parameter HDATA_WIDTH, default 32, which sets the data bus width.
REQ-002 The block SHALL have parameter HADDR_WIDTH, default 32, which sets the address bus width.
REQ-003 The block SHALL have parameter HPORT_COUNT, default 4, which sets the number of downstream ports (1..16).
REQ-004 The block SHALL have parameter PORT_BASE, a [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] array defaulting to all zeros, which gives each port's base address.
REQ-005 The block SHALL have parameter PORT_MASK, a [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] array defaulting to all zeros, which gives each port's compare mask (1 = bit compared); an all-zero mask disables the port.
REQ-006 HCLK  in  1  clock; all state SHALL update on its rising edge.
REQ-007 HRESETn  in  1  reset; it SHALL be synchronous and active-low.
REQ-008 s_HADDR/s_HBURST/s_HMASTLOCK/s_HPROT/s_HSIZE/s_HTRANS/s_HWDATA/s_HWRITE  in  HADDR_WIDTH/3/1/4/3/2/HDATA_WIDTH/1  upstream master request.
REQ-009 s_HRDATA/s_HREADY/s_HRESP  out  HDATA_WIDTH/1/1  upstream response.
REQ-010 m_HADDR/m_HBURST/m_HMASTLOCK/m_HPROT/m_HSIZE/m_HTRANS/m_HWDATA/m_HWRITE/m_HSEL/m_HREADY  out  [HPORT_COUNT] x request widths  per-port request.
REQ-011 m_HRDATA/m_HREADYOUT/m_HRESP  in  [HPORT_COUNT] x response widths  per-port response.
REQ-012 err_count  out  16  saturating count of ERROR responses generated by the default slave.

Function
REQ-013 Decode SHALL be internal and combinational: port i matches when (s_HADDR & PORT_MASK[i]) == (PORT_BASE[i] & PORT_MASK[i]) and PORT_MASK[i] != 0.
REQ-014 Overlapping matches SHALL resolve to the lowest index.
REQ-015 When no port matches, the transfer SHALL be routed to the internal default slave.
REQ-016 m_HSEL[i] SHALL be 1 only for the single winning port; m_HSEL SHALL be 0 for all ports on a miss.
REQ-017 All request signals and HWDATA SHALL be broadcast unmodified to every port.
REQ-018 m_HREADY[i] SHALL equal s_HREADY for all i, with no gating by any individual port.
REQ-019 A data-phase select register (one-hot over ports, plus a default flag) SHALL load the decode result on every cycle with s_HREADY=1 and SHALL hold while s_HREADY=0.
REQ-020 s_HRDATA, s_HREADY and s_HRESP SHALL be muxed combinationally from the selected port.
REQ-021 When the default slave is selected, s_HRDATA SHALL be 0.
REQ-022 The default slave FSM SHALL have states IDLE, ERR1 and ERR2.
REQ-023 IDLE: s_HREADY=1, s_HRESP=0 (OKAY).
REQ-024 IDLE->ERR1 SHALL occur when s_HREADY=1 and a NONSEQ(2) or SEQ(3) transfer misses decode.
REQ-025 IDLE/BUSY transfers that miss decode SHALL stay in IDLE with a zero-wait OKAY.
REQ-026 ERR1: s_HREADY=0, s_HRESP=1; it SHALL always advance to ERR2.
REQ-027 ERR2: s_HREADY=1, s_HRESP=1; it SHALL go to ERR1 if another mapped-out NONSEQ/SEQ arrives, otherwise to IDLE.
REQ-028 A hit during ERR2 SHALL load the select register normally.
REQ-029 err_count SHALL increment on each entry to ERR1 and saturate at 16'hFFFF.
REQ-030 A port's HREADYOUT/HRESP SHALL be ignored while that port is not selected in the data phase.
REQ-031 A port stalling with HREADYOUT=0 SHALL freeze the select register for the duration of the stall.
REQ-032 Latency: the block SHALL add zero cycles; the address phase SHALL reach the slave in the same cycle.

Reset
REQ-033 While HRESETn=0 at a clock edge, the select register SHALL clear to default, the FSM SHALL go to IDLE and err_count SHALL go to 0; as a result s_HREADY=1, s_HRESP=0 and s_HRDATA=0.
REQ-034 Reset asserted mid-stall or in ERR1 SHALL discard the transfer in progress; no ERR2 cycle SHALL follow.
REQ-035 Outputs driven from request inputs are combinational pass-throughs and are not altered by reset.

Verification
REQ-036 Scenario: PORT_BASE{0x0,0x1000_0000}, MASK{0xF000_0000}; NONSEQ read 0x1000_0004, port1 HRDATA=0xCAFE -> m_HSEL=2'b10; s_HRDATA=0xCAFE with s_HRESP=0 next cycle.
REQ-037 Scenario: port0 holds HREADYOUT=0 for 3 cycles while a pipelined NONSEQ to port1 is pending -> s_HREADY=0 for 3 cycles, port1 data is not muxed, and the select changes only after the stall.
REQ-038 Scenario: NONSEQ to unmapped 0xF000_0000 -> ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), then IDLE; err_count=1.
REQ-039 Scenario: IDLE transfer to an unmapped address -> OKAY with zero wait and err_count unchanged.
REQ-040 Scenario: two back-to-back unmapped NONSEQ -> ERR1, ERR2, ERR1, ERR2; err_count=2.
REQ-041 Scenario: overlapping windows on ports 1 and 2 -> only m_HSEL[1]=1.
REQ-042 Scenario: HRESETn=0 during ERR1 -> the next cycle shows s_HREADY=1, s_HRESP=0, err_count=0.
